state_machine_fsm: RTL and testbench
====================================

// Module: state_machine_fsm
// PURPOSE
//   Moore FSM that watches serial input w and asserts b while w has been sampled 1 on at
//   least RUN_LEN consecutive rising clk edges. Counts completed detections.
//   Sits between a synchronised control input and downstream enable logic.
// PARAMETERS
//   RUN_LEN  2  consecutive w=1 samples needed to assert b (legal range >= 1)
//   CNT_W    8  width of the saturating detection counter det_count
// PORTS
//   clk        input   1      rising-edge clock
//   rst        input   1      asynchronous, active-high reset
//   w          input   1      serial input, sampled on rising clk
//   b          output  1      detect flag; registered Moore output, decoded from state
//   det_count  output  CNT_W  number of entries into S_HIT, saturating
// BEHAVIOUR
// - Clocking and reset: one clock; reset is asynchronous and active-high.
//   - rst=1 forces state=S_IDLE, run_cnt=0, b=0, det_count=0 immediately, independent of clk.
//   - Reset asserted mid-run discards the partial run.
// - States (2-bit encoding): S_IDLE=2'b00, S_RUN=2'b01, S_HIT=2'b10. 2'b11 is illegal and recovers to S_IDLE next edge.
// - Internal run_cnt width is $clog2(RUN_LEN+1).
// - Transitions, evaluated on each rising clk:
//   - Any state with w=0 -> S_IDLE, run_cnt=0.
//   - S_IDLE, w=1:
//     - RUN_LEN==1: go to S_HIT.
//     - Otherwise: go to S_RUN with run_cnt=1.
//   - S_RUN, w=1: run_cnt+1.
//     - If run_cnt+1==RUN_LEN: go to S_HIT, run_cnt holds.
//     - Otherwise: stay in S_RUN.
//   - S_HIT, w=1: stay in S_HIT; b remains 1 for as long as w stays 1.
// - Output b:
//   - b=1 exactly when state==S_HIT.
//   - b rises on the RUN_LEN-th consecutive w=1 edge.
//   - b falls on the first edge that samples w=0.
//   - Latency is 0 cycles after the qualifying edge; no combinational path from w to b.
// - det_count:
//   - Increments by 1 on each transition into S_HIT.
//   - Saturates at 2^CNT_W-1 with no wrap.
//   - Staying in S_HIT does not increment it.
// - Boundary behaviour:
//   - A 0 sample one cycle short of RUN_LEN restarts the count from the next 1.
//   - w changes between edges are ignored (synchronous sampling only).
// - No handshake; w is assumed to be already synchronous to clk.
// CONFIGURATION
//   STATE_MACHINE_STATE_OUT_EN
//   - Defined: adds output port state_o [1:0] carrying the registered state encoding.
//     Reset value is 2'b00. Intended for debug and coverage.
//   - Undefined: the port does not exist; b and det_count behave identically either way.
// TESTING (clk period 100, defaults)
// 1. rst pulse with w=0, then 3 edges of w=0 -> b=0, det_count=0, state S_IDLE.
// 2. w=1 for 3 edges -> edge1 S_RUN, b=0; edge2 b=1, det_count=1; edge3 b=1, det_count=1.
//    w=0 on edge4 -> b=0.
// 3. Pattern 1,0,1,1 sampled -> b stays 0 until the 4th edge, then b=1, det_count=2.
// 4. w=1 held; assert rst between edges while b=1 -> b=0 and det_count=0 before the next edge.
//    Next edge with w=1 -> S_RUN, b=0.
// 5. CNT_W=2: produce 5 separate runs of two 1s -> det_count ends at 3 (saturated).
// 6. RUN_LEN=1 build: single w=1 edge -> b=1 on that edge.
//    With STATE_MACHINE_STATE_OUT_EN defined -> state_o=2'b10.

Source files
------------

// File: rtl/state_machine_fsm.sv
// state_machine_fsm: asserts b after RUN_LEN consecutive w=1 samples, counts hits; STATE_MACHINE_STATE_OUT_EN adds state_o
module state_machine_fsm #(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w,
  output logic             b,
  output logic [CNT_W-1:0] det_count
`ifdef STATE_MACHINE_STATE_OUT_EN
  ,
  output logic [1:0]       state_o
`endif
);
  localparam int RC_W = $clog2(RUN_LEN + 1);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_HIT = 2'b10} state_t;
  state_t state, state_nx;
  logic [RC_W-1:0] run_cnt, run_nx;
  always_comb begin
    state_nx = S_IDLE;
    run_nx   = '0;
    if (w && state == S_IDLE) begin
      state_nx = (RUN_LEN == 1) ? S_HIT : S_RUN;
      run_nx   = RC_W'(1);
    end else if (w && state == S_RUN) begin
      run_nx   = RC_W'(run_cnt + 1'b1);
      state_nx = (run_nx == RC_W'(RUN_LEN)) ? S_HIT : S_RUN;
    end else if (w && state == S_HIT) begin
      state_nx = S_HIT;
      run_nx   = run_cnt;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      run_cnt   <= '0;
      det_count <= '0;
    end else begin
      state   <= state_nx;
      run_cnt <= run_nx;
      if (state_nx == S_HIT && state != S_HIT && det_count != '1) det_count <= det_count + 1'b1;
    end
  end
  assign b = (state == S_HIT);
`ifdef STATE_MACHINE_STATE_OUT_EN
  assign state_o = state;
`endif
endmodule

// File: tb/tb_state_machine_fsm.sv
// tb_state_machine_fsm: scoreboard bench for default, CNT_W=2 and RUN_LEN=1 instances
module tb_state_machine_fsm;
  localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, HIT = 2'b10;
  typedef struct {
    int         id;
    string      nm;
    logic [1:0] st;
    logic       b;
    int         c;
  } exp_t;
  logic clk, rst, w0, w1, w2;
  logic b0, b1, b2;
  logic [7:0] dc0, dc2;
  logic [1:0] dc1;
  exp_t q[$];
  event chk_ev;
  int checks = 0;
  int errors = 0;
`ifdef STATE_MACHINE_STATE_OUT_EN
  logic [1:0] so0, so1, so2;
  state_machine_fsm u0 (.clk(clk), .rst(rst), .w(w0), .b(b0), .det_count(dc0), .state_o(so0));
  state_machine_fsm #(.RUN_LEN(2), .CNT_W(2)) u1 (.clk(clk), .rst(rst), .w(w1), .b(b1), .det_count(dc1), .state_o(so1));
  state_machine_fsm #(.RUN_LEN(1), .CNT_W(8)) u2 (.clk(clk), .rst(rst), .w(w2), .b(b2), .det_count(dc2), .state_o(so2));
`else
  state_machine_fsm u0 (.clk(clk), .rst(rst), .w(w0), .b(b0), .det_count(dc0));
  state_machine_fsm #(.RUN_LEN(2), .CNT_W(2)) u1 (.clk(clk), .rst(rst), .w(w1), .b(b1), .det_count(dc1));
  state_machine_fsm #(.RUN_LEN(1), .CNT_W(8)) u2 (.clk(clk), .rst(rst), .w(w2), .b(b2), .det_count(dc2));
`endif
  initial clk = 1'b0;
  always #50 clk = ~clk;
  task automatic push(input int id, input string nm, input logic [1:0] st, input logic eb, input int ec);
    exp_t e;
    e.id = id;
    e.nm = nm;
    e.st = st;
    e.b  = eb;
    e.c  = ec;
    q.push_back(e);
  endtask
  task automatic drive(input int id, input logic v);
    if (id == 0) w0 = v;
    else if (id == 1) w1 = v;
    else w2 = v;
  endtask
  task automatic step(input int id, input string nm, input logic wv, input bit glitch,
                      input logic [1:0] st, input logic eb, input int ec);
    @(negedge clk);
    drive(id, wv);
    if (glitch) begin
      #10 drive(id, ~wv);
      #20 drive(id, wv);
    end
    @(posedge clk);
    push(id, nm, st, eb, ec);
  endtask
  initial begin
    exp_t e;
    logic [1:0] a_st, a_so;
    logic a_b;
    int a_c;
    forever begin
      @(negedge clk or chk_ev);
      while (q.size() != 0) begin
        e = q.pop_front();
        if (e.id == 0) begin
          a_st = u0.state; a_b = b0; a_c = int'(dc0);
        end else if (e.id == 1) begin
          a_st = u1.state; a_b = b1; a_c = int'(dc1);
        end else begin
          a_st = u2.state; a_b = b2; a_c = int'(dc2);
        end
        a_so = e.st;
`ifdef STATE_MACHINE_STATE_OUT_EN
        a_so = (e.id == 0) ? so0 : (e.id == 1) ? so1 : so2;
`endif
        checks++;
        if (a_st !== e.st || a_b !== e.b || a_c != e.c || a_so !== e.st) begin
          errors++;
          $display("FAIL %s dut%0d: got state=%b b=%b cnt=%0d state_o=%b, want state=%b b=%b cnt=%0d",
                   e.nm, e.id, a_st, a_b, a_c, a_so, e.st, e.b, e.c);
        end
      end
    end
  end
  initial begin
    rst = 1'b1;
    w0 = 1'b0;
    w1 = 1'b0;
    w2 = 1'b0;
    #10 push(0, "rst_async", IDLE, 0, 0);
    push(1, "rst_async1", IDLE, 0, 0);
    push(2, "rst_async2", IDLE, 0, 0);
    ->chk_ev;
    @(negedge clk);
    #10 rst = 1'b0;
    step(0, "idle1", 0, 0, IDLE, 0, 0);
    step(0, "idle_glitch", 0, 1, IDLE, 0, 0);
    step(0, "idle3", 0, 0, IDLE, 0, 0);
    step(0, "run_e1", 1, 0, RUN, 0, 0);
    step(0, "run_e2", 1, 0, HIT, 1, 1);
    step(0, "run_e3", 1, 1, HIT, 1, 1);
    step(0, "run_e4", 0, 0, IDLE, 0, 1);
    step(0, "pat_1", 1, 0, RUN, 0, 1);
    step(0, "pat_0", 0, 0, IDLE, 0, 1);
    step(0, "pat_1b", 1, 0, RUN, 0, 1);
    step(0, "pat_1c", 1, 0, HIT, 1, 2);
    step(0, "hold", 1, 0, HIT, 1, 2);
    @(negedge clk);
    #10 rst = 1'b1;
    #1 push(0, "rst_mid", IDLE, 0, 0);
    ->chk_ev;
    #10 rst = 1'b0;
    @(posedge clk);
    push(0, "post_rst", RUN, 0, 0);
    step(0, "post_rst2", 1, 0, HIT, 1, 1);
    step(0, "post_rst3", 0, 0, IDLE, 0, 1);
    for (int i = 1; i <= 5; i++) begin
      step(1, "sat_a", 1, 0, RUN, 0, (i - 1 > 3) ? 3 : i - 1);
      step(1, "sat_b", 1, 0, HIT, 1, (i > 3) ? 3 : i);
      step(1, "sat_c", 0, 0, IDLE, 0, (i > 3) ? 3 : i);
    end
    step(2, "len1_e1", 1, 0, HIT, 1, 1);
    step(2, "len1_e2", 1, 0, HIT, 1, 1);
    step(2, "len1_e3", 0, 0, IDLE, 0, 1);
    step(2, "len1_e4", 1, 0, HIT, 1, 2);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
